cg_mem_arbiter: RTL

- N-requester to 1-memory arbiter for the CommonGoods valid/ready memory protocol.
- Read-address and write channels are arbitrated independently, round-robin.
- In-order read responses are routed back to the issuing requester through an outstanding-ID FIFO.
- Adds byte write strobes and multiple outstanding reads; sits between cores/DMA masters and a single memory slave.

---
 rtl/cg_mem_pkg.sv | 24 ++
 rtl/cg_mem_arbiter_rr.sv | 57 +++++
 rtl/cg_mem_arbiter.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/cg_mem_pkg.sv
// Shared width helpers for the CommonGoods memory arbiter slice.
package cg_mem_pkg;

    typedef int unsigned cg_width_t;

    function automatic cg_width_t cg_clog2(input cg_width_t value);
        cg_width_t result;
        result = 0;
        while ((cg_width_t'(1) << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

    // A single requester still needs a one-bit index so vectors never collapse to zero width.
    function automatic cg_width_t cg_idx_width(input cg_width_t num_ports);
        return (num_ports <= 2) ? cg_width_t'(1) : cg_clog2(num_ports);
    endfunction

    function automatic cg_width_t cg_strb_width(input cg_width_t data_width);
        return data_width / 8;
    endfunction

endpackage

// File: rtl/cg_mem_arbiter_rr.sv
// Round-robin arbiter with grant lock: holds its choice while the downstream side stalls.
module cg_rr_arbiter
    import cg_mem_pkg::*;
#(
    parameter int NUM_PORTS = 2,
    localparam int IW = int'(cg_idx_width(NUM_PORTS))
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_PORTS-1:0] req,
    input  logic                 hold,
    input  logic                 advance,
    output logic [NUM_PORTS-1:0] grant,
    output logic [IW-1:0]        grant_idx
);

    logic [IW-1:0] ptr;
    logic [IW-1:0] held_idx;
    logic          lock;
    logic [IW-1:0] search_idx;
    logic [IW-1:0] cand;
    logic [IW-1:0] next_ptr;
    logic          found;

    // Search begins at the pointer and wraps; a locked grant overrides the search.
    always_comb begin
        search_idx = ptr;
        found      = 1'b0;
        cand       = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            cand = IW'((int'(ptr) + i) % NUM_PORTS);
            if (!found && req[cand]) begin
                found      = 1'b1;
                search_idx = cand;
            end
        end
        grant_idx        = lock ? held_idx : search_idx;
        grant            = '0;
        grant[grant_idx] = req[grant_idx];
        next_ptr         = (grant_idx == IW'(NUM_PORTS - 1)) ? '0 : grant_idx + IW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr      <= '0;
            held_idx <= '0;
            lock     <= 1'b0;
        end else if (advance) begin
            ptr  <= next_ptr;
            lock <= 1'b0;
        end else if (hold) begin
            lock     <= 1'b1;
            held_idx <= grant_idx;
        end
    end

endmodule

// File: rtl/cg_mem_arbiter.sv
// N-to-1 memory arbiter: independent round-robin read-address and write channels,
// in-order read responses steered back through an outstanding-ID FIFO.
module cg_mem_arbiter
    import cg_mem_pkg::*;
#(
    parameter int NUM_PORTS       = 2,
    parameter int DATA_WIDTH      = 32,
    parameter int ADDR_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                              i_clk,
    input  logic                              i_rst,
    input  logic [NUM_PORTS-1:0]              i_raddr_valid,
    output logic [NUM_PORTS-1:0]              o_raddr_ready,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]   i_raddr,
    output logic [NUM_PORTS-1:0]              o_rdata_valid,
    input  logic [NUM_PORTS-1:0]              i_rdata_ready,
    output logic [DATA_WIDTH-1:0]             o_rdata,
    input  logic [NUM_PORTS-1:0]              i_wdata_valid,
    output logic [NUM_PORTS-1:0]              o_wdata_ready,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]   i_waddr,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]   i_wdata,
    input  logic [NUM_PORTS*DATA_WIDTH/8-1:0] i_wstrb,
    output logic                              o_m_raddr_valid,
    input  logic                              i_m_raddr_ready,
    output logic [ADDR_WIDTH-1:0]             o_m_raddr,
    input  logic                              i_m_rdata_valid,
    output logic                              o_m_rdata_ready,
    input  logic [DATA_WIDTH-1:0]             i_m_rdata,
    output logic                              o_m_wdata_valid,
    input  logic                              i_m_wdata_ready,
    output logic [ADDR_WIDTH-1:0]             o_m_waddr,
    output logic [DATA_WIDTH-1:0]             o_m_wdata,
    output logic [DATA_WIDTH/8-1:0]           o_m_wstrb,
    output logic                              o_err
);

    localparam int IW  = int'(cg_idx_width(NUM_PORTS));
    localparam int SW  = int'(cg_strb_width(DATA_WIDTH));
    localparam int FAW = int'(cg_clog2(MAX_OUTSTANDING));
    localparam logic [FAW:0] FIFO_FULL_COUNT = (FAW+1)'(MAX_OUTSTANDING);

    logic [NUM_PORTS-1:0] rd_grant;
    logic [IW-1:0]        rd_idx;
    logic                 rd_hs;
    logic                 rd_hold;
    logic [NUM_PORTS-1:0] wr_grant;
    logic [IW-1:0]        wr_idx;
    logic                 wr_hs;
    logic                 wr_hold;

    logic [IW-1:0]  fifo_mem [MAX_OUTSTANDING];
    logic [FAW-1:0] fifo_wr_ptr;
    logic [FAW-1:0] fifo_rd_ptr;
    logic [FAW:0]   fifo_count;
    logic           fifo_full;
    logic           fifo_empty;
    logic [IW-1:0]  head;
    logic           rsp_pop;

    cg_rr_arbiter #(.NUM_PORTS(NUM_PORTS)) u_rd_arb (
        .clk       (i_clk),
        .rst       (i_rst),
        .req       (i_raddr_valid),
        .hold      (rd_hold),
        .advance   (rd_hs),
        .grant     (rd_grant),
        .grant_idx (rd_idx)
    );

    cg_rr_arbiter #(.NUM_PORTS(NUM_PORTS)) u_wr_arb (
        .clk       (i_clk),
        .rst       (i_rst),
        .req       (i_wdata_valid),
        .hold      (wr_hold),
        .advance   (wr_hs),
        .grant     (wr_grant),
        .grant_idx (wr_idx)
    );

    assign fifo_full  = (fifo_count == FIFO_FULL_COUNT);
    assign fifo_empty = (fifo_count == '0);
    assign head       = fifo_mem[fifo_rd_ptr];

    // Full blocks issue on the registered count only, keeping rdata off the raddr path.
    assign o_m_raddr_valid = !i_rst && (|rd_grant) && !fifo_full;
    assign o_raddr_ready   = (!i_rst && i_m_raddr_ready && !fifo_full) ? rd_grant : '0;
    assign o_m_raddr       = i_raddr[int'(rd_idx)*ADDR_WIDTH +: ADDR_WIDTH];
    assign rd_hs           = o_m_raddr_valid && i_m_raddr_ready;
    assign rd_hold         = o_m_raddr_valid && !i_m_raddr_ready;

    assign o_m_wdata_valid = !i_rst && (|wr_grant);
    assign o_wdata_ready   = (!i_rst && i_m_wdata_ready) ? wr_grant : '0;
    assign o_m_waddr       = i_waddr[int'(wr_idx)*ADDR_WIDTH +: ADDR_WIDTH];
    assign o_m_wdata       = i_wdata[int'(wr_idx)*DATA_WIDTH +: DATA_WIDTH];
    assign o_m_wstrb       = i_wstrb[int'(wr_idx)*SW +: SW];
    assign wr_hs           = o_m_wdata_valid && i_m_wdata_ready;
    assign wr_hold         = o_m_wdata_valid && !i_m_wdata_ready;

    // With nothing outstanding the memory side is drained so a stray response cannot stall it.
    always_comb begin
        o_rdata_valid   = '0;
        o_m_rdata_ready = 1'b0;
        if (!i_rst) begin
            if (fifo_empty) begin
                o_m_rdata_ready = 1'b1;
            end else begin
                o_rdata_valid[head] = i_m_rdata_valid;
                o_m_rdata_ready     = i_rdata_ready[head];
            end
        end
    end

    assign o_rdata = i_m_rdata;
    assign rsp_pop = !fifo_empty && i_m_rdata_valid && o_m_rdata_ready;

    always_ff @(posedge i_clk) begin
        if (rd_hs) begin
            fifo_mem[fifo_wr_ptr] <= rd_idx;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            fifo_wr_ptr <= '0;
            fifo_rd_ptr <= '0;
            fifo_count  <= '0;
        end else begin
            if (rd_hs) begin
                fifo_wr_ptr <= fifo_wr_ptr + FAW'(1);
            end
            if (rsp_pop) begin
                fifo_rd_ptr <= fifo_rd_ptr + FAW'(1);
            end
            case ({rd_hs, rsp_pop})
                2'b10:   fifo_count <= fifo_count + (FAW+1)'(1);
                2'b01:   fifo_count <= fifo_count - (FAW+1)'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_err <= 1'b0;
        end else if (fifo_empty && i_m_rdata_valid) begin
            o_err <= 1'b1;
        end
    end

endmodule
